fetch_buffer: RTL and testbench

- Front-end instruction queue between the icache/fetch port and the seven-decoder/segmenter decode stage.
- Accepts 16-byte aligned lines through a valid/ready handshake and stores them as halfwords in a circular buffer.
- Presents a halfword-aligned 16-byte decode window starting at the current PC.
- Consumes the variable byte advance (0..16, even) returned by decode/segment, and tracks the fetch address and the decode PC.

---
 rtl/fetch_buffer.sv | 177 +++++++++++++++++
 tb/tb_fetch_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//
// Instruction queue between the fetch port and the decode/segment stage.
// Whole 16-byte lines come in through a valid/ready handshake and are stored
// as halfwords in a circular buffer. Decode sees a 16-byte, halfword-aligned
// window that starts at the current PC. Each cycle decode returns how many
// bytes it consumed.
//
// Handshake: a line transfers on a rising clock edge when i_line_valid and
// o_line_ready are both high and i_flush is low. o_line_ready depends only on
// registered state. While the line is not taken, the source holds
// i_line_data stable.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   o_fetch_addr         16-byte-aligned address of the next line to fetch
//   i_line_valid/o_line_ready/i_line_data   line input handshake + data
//   o_window             16 bytes starting at o_window_pc (invalid hw = 0)
//   o_window_hw          number of valid halfwords in the window (0..8)
//   o_window_pc          address of window byte 0
//   i_advance            bytes consumed by decode (even, 0..16)
//   i_flush              redirect; i_flush_target gives the new PC
//   o_starve_cycles      (only when FETCH_BUF_STATS_EN is defined) saturating
//                        count of non-flush cycles with fewer than 8 valid hw
//
// Optional feature macro: FETCH_BUF_STATS_EN
// ---------------------------------------------------------------------------
module fetch_buffer #(
    parameter logic [31:0] RESET_VECTOR = 32'h80000000,
    parameter int          DEPTH_LINES  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [31:0]  o_fetch_addr,
    input  logic         i_line_valid,
    output logic         o_line_ready,
    input  logic [127:0] i_line_data,
    output logic [127:0] o_window,
    output logic [3:0]   o_window_hw,
    output logic [31:0]  o_window_pc,
    input  logic [4:0]   i_advance,
    input  logic         i_flush,
    input  logic [31:0]  i_flush_target
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [31:0]  o_starve_cycles
`endif
);

    localparam int CAP = 8 * DEPTH_LINES;   // capacity in halfwords
    localparam int PW  = $clog2(CAP);       // halfword pointer width
    localparam int CW  = PW + 1;            // count width (0..CAP)

    // Storage and state
    logic [15:0]   mem_q [CAP];
    logic [PW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [2:0]    skip_q, skip_d;

    // Datapath helpers
    logic [3:0]    win_hw;
    logic          line_ready;
    logic          accept;
    logic [3:0]    adv_raw;
    logic [3:0]    adv_hw;
    logic [3:0]    acc_hw;
    logic [PW-1:0] wr_base;
    logic [127:0]  window;

    // Bit 0 of the advance and of the redirect target carry no information.
    logic unused_bits;
    assign unused_bits = ^{i_advance[0], i_flush_target[0]};

    assign win_hw     = (count_q >= CW'(8)) ? 4'd8 : count_q[3:0];
    assign line_ready = (CW'(CAP) - count_q) >= CW'(8);
    assign accept     = i_line_valid & line_ready & ~i_flush;
    assign adv_raw    = i_advance[4:1];
    // Decode can never consume halfwords that are not in the window.
    assign adv_hw     = (adv_raw > win_hw) ? win_hw : adv_raw;
    assign acc_hw     = accept ? (4'd8 - {1'b0, skip_q}) : 4'd0;
    // Write position is the slot just past the last valid halfword. A write
    // only happens when ready, so count_q < CAP and this cannot overlap head.
    assign wr_base    = head_q + count_q[PW-1:0];

    // Window read: the pointer arithmetic wraps modulo CAP on its own.
    always_comb begin
        window = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < win_hw) begin
                window[16*k +: 16] = mem_q[head_q + PW'(k)];
            end
        end
    end

    // Next-state logic; flush wins over accept and advance.
    always_comb begin
        head_d       = head_q;
        count_d      = count_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        if (i_flush) begin
            head_d       = '0;
            count_d      = '0;
            pc_d         = {i_flush_target[31:1], 1'b0};
            fetch_addr_d = {i_flush_target[31:4], 4'b0000};
            skip_d       = i_flush_target[3:1];
        end else begin
            head_d  = head_q + PW'(adv_hw);
            count_d = count_q + CW'(acc_hw) - CW'(adv_hw);
            pc_d    = pc_q + 32'({adv_hw, 1'b0});
            if (accept) begin
                fetch_addr_d = fetch_addr_q + 32'd16;
                skip_d       = 3'd0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q       <= '0;
            count_q      <= '0;
            pc_q         <= RESET_VECTOR;
            fetch_addr_q <= {RESET_VECTOR[31:4], 4'b0000};
            skip_q       <= RESET_VECTOR[3:1];
        end else begin
            head_q       <= head_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
        end
    end

    // Storage is not reset: halfwords outside the valid range read as zero.
    // Halfwords below skip belong to bytes before the target PC and are dropped.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (3'(k) >= skip_q) begin
                    mem_q[wr_base + PW'(k) - PW'(skip_q)] <= i_line_data[16*k +: 16];
                end
            end
        end
    end

    assign o_fetch_addr = fetch_addr_q;
    assign o_line_ready = line_ready;
    assign o_window     = window;
    assign o_window_hw  = win_hw;
    assign o_window_pc  = pc_q;

`ifdef FETCH_BUF_STATS_EN
    logic [31:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if ((win_hw < 4'd8) && !i_flush && (starve_q != 32'hFFFF_FFFF)) begin
            starve_d = starve_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign o_starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer. The reference model holds the buffered instruction
// stream as a queue of halfwords plus pc / fetch address / skip. Expected
// outputs are pushed into a queue once per cycle. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs.
module tb_fetch_buffer;
  localparam logic [31:0] RV  = 32'h80000000;
  localparam int          CAP = 32;
  localparam int          W   = 197;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  fetch_addr;
  logic         line_valid = 1'b0;
  logic         line_ready;
  logic [127:0] line_data = '0;
  logic [127:0] window;
  logic [3:0]   window_hw;
  logic [31:0]  window_pc;
  logic [4:0]   advance = '0;
  logic         flush = 1'b0;
  logic [31:0]  flush_target = '0;
`ifdef FETCH_BUF_STATS_EN
  logic [31:0]  starve_cycles;
  logic [31:0]  st_q[$];
  logic [31:0]  m_starve;
`endif

  int total = 0;
  int bad   = 0;

  // exp entry: {window[127:0], hw[3:0], pc[31:0], fetch_addr[31:0], ready}
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [15:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fa;
  int          m_skip;

  fetch_buffer #(.RESET_VECTOR(RV), .DEPTH_LINES(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_fetch_addr   (fetch_addr),
    .i_line_valid   (line_valid),
    .o_line_ready   (line_ready),
    .i_line_data    (line_data),
    .o_window       (window),
    .o_window_hw    (window_hw),
    .o_window_pc    (window_pc),
    .i_advance      (advance),
    .i_flush        (flush),
    .i_flush_target (flush_target)
`ifdef FETCH_BUF_STATS_EN
    ,
    .o_starve_cycles(starve_cycles)
`endif
  );

  // clock block
  always #5 clk = ~clk;

  // memory image seen by the fetch port
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] + a[15:8] + a[23:16] + a[31:24] - 8'h80;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] fa);
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[8*b +: 8] = mbyte(fa + 32'(b));
    return l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc   = RV;
    m_fa   = RV & ~32'hF;
    m_skip = int'(RV[3:1]);
`ifdef FETCH_BUF_STATS_EN
    m_starve = 0;
`endif
  endfunction

  // Apply the inputs present at this clock edge to the model.
  function automatic void model_update();
    int sz  = mq.size();
    int win = (sz > 8) ? 8 : sz;
    int adv;
    bit rdy;
`ifdef FETCH_BUF_STATS_EN
    if (win < 8 && !flush && m_starve != 32'hFFFFFFFF) m_starve++;
`endif
    if (flush) begin
      mq.delete();
      m_pc   = flush_target & ~32'h1;
      m_fa   = flush_target & ~32'hF;
      m_skip = int'(flush_target[3:1]);
    end else begin
      rdy = (CAP - sz) >= 8;
      adv = int'(advance) / 2;
      if (adv > win) adv = win;
      for (int i = 0; i < adv; i++) void'(mq.pop_front());
      m_pc = m_pc + 32'(2 * adv);
      if (line_valid && rdy) begin
        for (int k = m_skip; k < 8; k++) mq.push_back(line_data[16*k +: 16]);
        m_fa   = m_fa + 32'd16;
        m_skip = 0;
      end
    end
  endfunction

  function automatic void push_expected();
    logic [127:0] w = '0;
    int sz = mq.size();
    logic [3:0] hw = (sz > 8) ? 4'd8 : 4'(sz);
    for (int k = 0; k < 8; k++) if (k < sz) w[16*k +: 16] = mq[k];
    exp_q.push_back({w, hw, m_pc, m_fa, 1'((CAP - sz) >= 8)});
`ifdef FETCH_BUF_STATS_EN
    st_q.push_back(m_starve);
`endif
  endfunction

  // driver: one clock cycle. The edge consumes the inputs driven last time.
  task automatic step(input bit v, input int adv, input bit fl, input logic [31:0] tgt);
    @(posedge clk);
    model_update();
    #1;
    push_expected();
    line_valid   = v;
    advance      = 5'(adv);
    flush        = fl;
    flush_target = tgt;
    line_data    = line_of(m_fa);
  endtask

  task automatic check_reset_outputs();
    chk("rst_window_hw", 128'(window_hw), 128'(0));
    chk("rst_window", window, 128'(0));
    chk("rst_window_pc", 128'(window_pc), 128'(RV));
    chk("rst_fetch_addr", 128'(fetch_addr), 128'(RV & ~32'hF));
    chk("rst_line_ready", 128'(line_ready), 128'(1));
`ifdef FETCH_BUF_STATS_EN
    chk("rst_starve", 128'(starve_cycles), 128'(0));
`endif
  endtask

  // Reset is asserted between clock edges, after the pending compare is done.
  task automatic do_reset();
    @(negedge clk);
    #2;
    line_valid = 1'b0;
    advance    = '0;
    flush      = 1'b0;
    rst        = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("window", window, e[196:69]);
        chk("window_hw", 128'(window_hw), 128'(e[68:65]));
        chk("window_pc", 128'(window_pc), 128'(e[64:33]));
        chk("fetch_addr", 128'(fetch_addr), 128'(e[32:1]));
        chk("line_ready", 128'(line_ready), 128'(e[0]));
`ifdef FETCH_BUF_STATS_EN
        if (st_q.size() > 0) chk("starve", 128'(starve_cycles), 128'(st_q.pop_front()));
`endif
      end
    end
  end

  // stimulus
  initial begin
    model_reset();
    @(negedge clk);
    #2;
    check_reset_outputs();
    rst = 1'b0;

    // fill until full, then release one line
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 16, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

    // steady stream, alternating 6/10 byte advances, well past a storage wrap
    for (int i = 0; i < 80; i++) step(1, (i % 2) ? 10 : 6, 0, 0);

    // flush with a same-cycle line and advance, then refill from mid-line
    step(1, 8, 1, 32'h80000106);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);

    // clamp: one line buffered, eat 16, then try to eat from an empty buffer
    step(0, 0, 1, 32'h80000300);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 16, 0, 0);
    step(0, 4, 0, 0);
    step(0, 0, 0, 0);

    // randomized traffic with occasional redirects, including near 2^32 wrap
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFC0 | 32'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, 2 * $urandom_range(0, 8),
           $urandom_range(0, 39) == 0, tgt);
    end

    // build count=20, then reset asynchronously
    step(0, 0, 1, 32'h80000200);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 8, 0, 0);
    step(1, 6, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 2 * $urandom_range(0, 8), 0, 0);
    step(0, 0, 0, 0);

    @(negedge clk);
    #1;
    chk("drain", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
